toggle_lock_checker: RTL

- Receive-side checker for the two-state toggle generator. The generator drives 0,1,0,1... on alternate clk cycles.
- Samples the incoming single-bit stream and declares lock after a configurable run of correct alternations.
- Counts and flags missed toggles while locked, and drops lock after a configurable run of consecutive misses.
- Sits in the same clk domain as the generator, as a built-in self-test monitor on the generator output.

---
 rtl/toggle_pkg.sv | 15 +
 rtl/toggle_detect.sv | 31 +++
 rtl/toggle_lock_checker.sv | 119 +++++++++++
 3 files changed

// File: rtl/toggle_pkg.sv
// Shared definitions for the toggle lock checker.
//   state_t : FSM state encoding (2-bit), also exported on state_o
//   CNT_W   : width of the good/bad run counters
package toggle_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    S_HUNT   = 2'd0,
    S_VERIFY = 2'd1,
    S_LOCKED = 2'd2,
    S_SLIP   = 2'd3
  } state_t;

endpackage

// File: rtl/toggle_detect.sv
// Sample register and toggle detector for the incoming toggle stream.
//   clk, reset : rising-edge clock, async active-high reset
//   en         : sample enable; when low, the last sample is held
//   din        : toggle stream under test
//   toggle     : din differs from the last enabled sample (needs a valid sample)
module toggle_detect (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic din,
  output logic toggle
);

  logic last;
  logic have_last;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last      <= 1'b0;
      have_last <= 1'b0;
    end else if (en) begin
      last      <= din;
      have_last <= 1'b1;
    end
  end

  // Combinational against the current din; the very first sample after reset
  // has nothing to compare with, so it never counts as a toggle.
  assign toggle = have_last & (din ^ last);

endmodule

// File: rtl/toggle_lock_checker.sv
// Receive-side lock checker for a 0,1,0,1... toggle stream.
//   clk, reset  : rising-edge clock, async active-high reset
//   en          : sample enable; low freezes all state except clr_err
//   clr_err     : synchronous clear of err_count (wins over an increment)
//   din         : toggle stream under test (same clock domain)
//   locked      : high while in LOCKED or SLIP
//   error_pulse : one-cycle pulse per missed toggle while locked
//   err_count   : saturating count of missed toggles
//   expect_nxt  : expected din at the next enabled edge (~last sample)
//   state_o     : current FSM state (debug)
// No valid/ready handshake here: every enabled edge is one sample.
module toggle_lock_checker
  import toggle_pkg::*;
#(
  parameter int LOCK_COUNT = 4,
  parameter int LOSS_COUNT = 2,
  parameter int ERR_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr_err,
  input  logic             din,
  output logic             locked,
  output logic             error_pulse,
  output logic [ERR_W-1:0] err_count,
  output logic             expect_nxt,
  output logic [1:0]       state_o
);

  localparam logic [CNT_W-1:0] LOCK_C  = CNT_W'(LOCK_COUNT);
  localparam logic [CNT_W-1:0] LOSS_C  = CNT_W'(LOSS_COUNT);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);
  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  state_t           state;
  logic [CNT_W-1:0] good_cnt;
  logic [CNT_W-1:0] bad_cnt;
  logic             toggle;
  logic             miss;

  toggle_detect u_detect (
    .clk    (clk),
    .reset  (reset),
    .en     (en),
    .din    (din),
    .toggle (toggle)
  );

  // A miss only exists while locked; in HUNT/VERIFY a repeat just restarts.
  assign miss = en & ~toggle & ((state == S_LOCKED) | (state == S_SLIP));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_HUNT;
      good_cnt    <= '0;
      bad_cnt     <= '0;
      error_pulse <= 1'b0;
      expect_nxt  <= 1'b0;
    end else begin
      error_pulse <= miss;
      if (en) begin
        expect_nxt <= ~din;
        case (state)
          S_HUNT: begin
            if (toggle) begin
              good_cnt <= ONE_C;
              state    <= (LOCK_C == ONE_C) ? S_LOCKED : S_VERIFY;
            end
          end
          S_VERIFY: begin
            if (toggle) begin
              good_cnt <= good_cnt + ONE_C;
              if (good_cnt + ONE_C == LOCK_C) state <= S_LOCKED;
            end else begin
              good_cnt <= '0;
              state    <= S_HUNT;
            end
          end
          S_LOCKED: begin
            if (!toggle) begin
              bad_cnt <= ONE_C;
              if (LOSS_C == ONE_C) begin
                good_cnt <= '0;
                state    <= S_HUNT;
              end else begin
                state <= S_SLIP;
              end
            end
          end
          S_SLIP: begin
            if (toggle) begin
              bad_cnt <= '0;
              state   <= S_LOCKED;
            end else begin
              bad_cnt <= bad_cnt + ONE_C;
              if (bad_cnt + ONE_C == LOSS_C) begin
                good_cnt <= '0;
                state    <= S_HUNT;
              end
            end
          end
          default: state <= S_HUNT;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                          err_count <= '0;
    else if (clr_err)                   err_count <= '0;
    else if (miss && err_count != ERR_MAX) err_count <= err_count + 1'b1;
  end

  // Both locked states share the MSB of the encoding.
  assign locked  = state[1];
  assign state_o = state;

endmodule
